ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (Rs/Rt data, funct, R-type qualifier).
- Implements MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO against architectural HI/LO registers.
- Multi-cycle operations run in the background while the pipeline continues.
- o_stall is the interlock to the hazard unit: it freezes PC and IF/ID, holds ID/EX, and forces a bubble into EX/MEM whenever a HI/LO-dependent or mul/div instruction reaches EX while the unit is busy.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_core.sv | 87 ++++++++
 rtl/ex_muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes,
// FSM state encoding and funct classification helpers.
package muldiv_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // True for the four multi-cycle operations.
  function automatic logic is_muldiv_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // True for every instruction that reads or writes HI/LO.
  function automatic logic is_hilo_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
           (f == FUNCT_MFLO) || (f == FUNCT_MTLO) ||
           is_muldiv_funct(f);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring
// subtract (divide) step per clock on a 2*NBITS accumulator.
// Both operations load {0, first operand} into the accumulator, so the
// final layout is {product_hi, product_lo} or {remainder, quotient}.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_is_div,
  input  logic [NBITS-1:0]   i_a,
  input  logic [NBITS-1:0]   i_b,
  output logic               o_done,
  output logic [2*NBITS-1:0] o_acc
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(NBITS - 1);

  logic [2*NBITS-1:0] r_acc;
  logic [NBITS-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_active;
  logic               r_is_div;

  logic [NBITS:0]     w_mul_sum;
  logic [NBITS:0]     w_div_shift;
  logic [NBITS:0]     w_div_trial;
  logic [2*NBITS-1:0] w_next;

  // Next accumulator value for a single multiply or divide step.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*NBITS-1:NBITS]} + {1'b0, r_b};
    w_div_shift = {r_acc[2*NBITS-1:NBITS], r_acc[NBITS-1]};
    w_div_trial = w_div_shift - {1'b0, r_b};
    w_next      = r_acc;
    if (r_is_div) begin
      // Borrow out means the divisor did not fit: keep the shifted remainder.
      if (w_div_trial[NBITS]) begin
        w_next = {w_div_shift[NBITS-1:0], r_acc[NBITS-2:0], 1'b0};
      end else begin
        w_next = {w_div_trial[NBITS-1:0], r_acc[NBITS-2:0], 1'b1};
      end
    end else begin
      // Carry of the add is shifted into the top so no product bit is lost.
      if (r_acc[0]) begin
        w_next = {w_mul_sum, r_acc[NBITS-1:1]};
      end else begin
        w_next = {1'b0, r_acc[2*NBITS-1:1]};
      end
    end
  end

  assign o_done = r_active && (r_cnt == LAST_STEP);
  assign o_acc  = r_acc;

  // Operand load on start, then NBITS steps while active.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_is_div <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {{NBITS{1'b0}}, i_a};
      r_b      <= i_b;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_is_div <= i_is_div;
    end else if (r_active) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) begin
        r_active <= 1'b0;
      end else begin
        r_active <= 1'b1;
      end
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, the IDLE/MUL/DIV/FIX control,
// signed-operand handling around the unsigned core, and the hazard interlock.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int FBITS = FUNCT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [FBITS-1:0] i_funct,
  input  logic [NBITS-1:0] i_rs,
  input  logic [NBITS-1:0] i_rt,
  output logic             o_stall,
  output logic             o_busy,
  output logic [NBITS-1:0] o_result,
  output logic [NBITS-1:0] o_hi,
  output logic [NBITS-1:0] o_lo
);

  localparam logic [NBITS-1:0]   ZERO   = '0;
  localparam logic [2*NBITS-1:0] ZERO_W = '0;

  state_t           r_state;
  logic [NBITS-1:0] r_hi;
  logic [NBITS-1:0] r_lo;
  logic [NBITS-1:0] r_rs_raw;
  logic             r_res_neg;
  logic             r_rem_neg;
  logic             r_div_zero;
  logic             r_op_div;

  logic               w_accept;
  logic               w_is_div;
  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [NBITS-1:0]   w_a_mag;
  logic [NBITS-1:0]   w_b_mag;
  logic               w_done;
  logic [2*NBITS-1:0] w_acc;
  logic [2*NBITS-1:0] w_prod;
  logic [NBITS-1:0]   w_fix_hi;
  logic [NBITS-1:0]   w_fix_lo;

  // Decode the EX instruction and form unsigned operand magnitudes.
  always_comb begin
    w_is_div = (i_funct == FUNCT_DIV) || (i_funct == FUNCT_DIVU);
    w_signed = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);
    w_accept = (r_state == ST_IDLE) && i_valid && is_muldiv_funct(i_funct);
    w_rs_neg = w_signed && i_rs[NBITS-1];
    w_rt_neg = w_signed && i_rt[NBITS-1];
    w_a_mag  = w_rs_neg ? (ZERO - i_rs) : i_rs;
    w_b_mag  = w_rt_neg ? (ZERO - i_rt) : i_rt;
  end

  muldiv_core #(
    .NBITS (NBITS)
  ) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_accept),
    .i_is_div (w_is_div),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_done   (w_done),
    .o_acc    (w_acc)
  );

  // Sign correction and special cases applied to the raw core result.
  always_comb begin
    w_prod = r_res_neg ? (ZERO_W - w_acc) : w_acc;
    if (r_op_div) begin
      if (r_div_zero) begin
        w_fix_hi = r_rs_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = r_res_neg ? (ZERO - w_acc[NBITS-1:0]) : w_acc[NBITS-1:0];
        w_fix_hi = r_rem_neg ? (ZERO - w_acc[2*NBITS-1:NBITS]) : w_acc[2*NBITS-1:NBITS];
      end
    end else begin
      w_fix_hi = w_prod[2*NBITS-1:NBITS];
      w_fix_lo = w_prod[NBITS-1:0];
    end
  end

  // Control FSM with HI/LO architectural state and operation flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_rs_raw   <= '0;
      r_res_neg  <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_div_zero <= 1'b0;
      r_op_div   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rs_raw   <= i_rs;
            r_res_neg  <= w_rs_neg ^ w_rt_neg;
            r_rem_neg  <= w_rs_neg;
            r_div_zero <= w_is_div && (i_rt == ZERO);
            r_op_div   <= w_is_div;
            r_state    <= w_is_div ? ST_DIV : ST_MUL;
          end else if (i_valid && (i_funct == FUNCT_MTHI)) begin
            r_hi <= i_rs;
          end else if (i_valid && (i_funct == FUNCT_MTLO)) begin
            r_lo <= i_rs;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_done) begin
            r_state <= ST_FIX;
          end else begin
            r_state <= r_state;
          end
        end
        ST_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_stall = o_busy && i_valid && is_hilo_funct(i_funct);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

  // Move-from-HI/LO read port.
  always_comb begin
    if (i_valid && (i_funct == FUNCT_MFHI)) begin
      o_result = r_hi;
    end else if (i_valid && (i_funct == FUNCT_MFLO)) begin
      o_result = r_lo;
    end else begin
      o_result = '0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an arithmetic reference model of
// HI/LO and the busy window, checked every cycle, plus literal directed checks.
module tb_ex_muldiv_unit;

  localparam int LAT = 33;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        o_stall;
  logic        o_busy;
  logic [31:0] o_result;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // reference model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_funct  (funct),
    .i_rs     (rs),
    .i_rt     (rt),
    .o_stall  (o_stall),
    .o_busy   (o_busy),
    .o_result (o_result),
    .o_hi     (o_hi),
    .o_lo     (o_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_md(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  // Returns {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (f)
      F_MULTU: p = {32'd0, a} * {32'd0, b};
      F_MULT:  p = 64'(sa * sb);
      F_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else            p = {a % b, a / b};
      end
      F_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Reference model update on each active edge.
  always @(posedge clk) begin
    if (rst) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 64'd0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) {m_hi, m_lo} <= m_pend;
    end else if (valid && is_md(funct)) begin
      m_pend <= model_op(funct, rs, rt);
      m_left <= LAT;
    end else if (valid && funct == F_MTHI) begin
      m_hi <= rs;
    end else if (valid && funct == F_MTLO) begin
      m_lo <= rs;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic        e_busy;
    logic        e_stall;
    logic [31:0] e_res;
    if (chk_en) begin
      e_busy  = (m_left > 0);
      e_stall = e_busy && valid && is_hilo(funct);
      if (valid && funct == F_MFHI)      e_res = m_hi;
      else if (valid && funct == F_MFLO) e_res = m_lo;
      else                               e_res = 32'd0;
      check("busy",   64'(o_busy),   64'(e_busy));
      check("stall",  64'(o_stall),  64'(e_stall));
      check("result", 64'(o_result), 64'(e_res));
      check("hi",     64'(o_hi),     64'(m_hi));
      check("lo",     64'(o_lo),     64'(m_lo));
    end
  end

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    valid = v;
    funct = f;
    rs    = a;
    rt    = b;
  endtask

  // Issue one op, count busy cycles, then check HI/LO against literals.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cnt;
    drive(1'b1, f, a, b);
    drive(1'b0, 6'h00, $urandom, $urandom);
    cnt = 0;
    @(negedge clk);
    while (o_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(LAT));
    check({name, "_hi"}, 64'(o_hi), 64'(eh));
    check({name, "_lo"}, 64'(o_lo), 64'(el));
  endtask

  initial begin
    int cnt;
    rst   = 1'b1;
    valid = 1'b0;
    funct = 6'h00;
    rs    = 32'd0;
    rt    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_hi",   64'(o_hi),   64'd0);
    check("reset_lo",   64'(o_lo),   64'd0);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    rst = 1'b0;

    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_nn",   F_MULT,  32'hFFFFFFFB, 32'hFFFFFFFD, 32'h00000000, 32'h0000000F);
    run_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_zero",  F_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_big",  F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    run_op("div_pn",    F_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);

    // MULT followed immediately by a held MFLO
    drive(1'b1, F_MULT, 32'd6, 32'd7);
    drive(1'b1, F_MFLO, 32'd0, 32'd0);
    cnt = 0;
    @(negedge clk);
    while (o_stall && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("mflo_stall_cycles", 64'(cnt), 64'(LAT));
    check("mflo_result", 64'(o_result), 64'h2A);
    check("mflo_no_stall", 64'(o_stall), 64'd0);

    // MULT followed by a non-HI/LO instruction never stalls
    drive(1'b1, F_MULT, 32'd3, 32'd5);
    drive(1'b1, F_ADD, 32'd1, 32'd2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_stall) cnt++;
    end
    check("add_stall_cycles", 64'(cnt), 64'd0);
    check("add_lo", 64'(o_lo), 64'd15);

    // MTHI held while busy must not land until the unit is idle
    drive(1'b1, F_MULTU, 32'd2, 32'd3);
    drive(1'b1, F_MTHI, 32'hA5A5A5A5, 32'd0);
    cnt = 0;
    @(negedge clk);
    while (o_stall && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("mthi_stall_cycles", 64'(cnt), 64'(LAT));
    check("mthi_hi_before", 64'(o_hi), 64'd0);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_hi_after", 64'(o_hi), 64'hA5A5A5A5);
    check("mthi_lo_kept", 64'(o_lo), 64'd6);

    // MTHI then MFHI back-to-back in idle
    drive(1'b1, F_MTHI, 32'h12345678, 32'd0);
    drive(1'b1, F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("mfhi_result", 64'(o_result), 64'h12345678);
    check("mfhi_no_stall", 64'(o_stall), 64'd0);
    drive(1'b1, F_MTLO, 32'hCAFEF00D, 32'd0);
    drive(1'b0, F_MTHI, 32'h0BAD0BAD, 32'd0);
    @(negedge clk);
    check("mtlo_lo", 64'(o_lo), 64'hCAFEF00D);
    check("invalid_mthi_ignored", 64'(o_hi), 64'h12345678);

    // reset on the 10th iteration of a DIVU
    drive(1'b1, F_DIVU, 32'd1000, 32'd3);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    check("rst_mid_hi",   64'(o_hi),   64'd0);
    check("rst_mid_lo",   64'(o_lo),   64'd0);
    drive(1'b1, F_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_mflo_result", 64'(o_result), 64'd0);
    check("rst_mflo_stall",  64'(o_stall),  64'd0);
    drive(1'b0, 6'h00, 32'd0, 32'd0);

    // after reset the unit still works
    run_op("post_rst", F_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
